// File: rtl/player_op_exec_pkg.sv
// Shared widths, op codes and FSM state type for the player op executor.
// Op code values mirror the game-wide bus definitions used by the input stage.
package player_op_exec_pkg;

  localparam int X_W         = 4;
  localparam int Y_W         = 5;
  localparam int BOARD_H     = 20;
  localparam int PIECE_ROT_W = 2;

  localparam logic [Y_W-1:0] Y_LAST = Y_W'(BOARD_H - 1);

  localparam logic [2:0] OP_NULL  = 3'd0;
  localparam logic [2:0] OP_LEFT  = 3'd1;
  localparam logic [2:0] OP_RIGHT = 3'd2;
  localparam logic [2:0] OP_SPIN  = 3'd3;
  localparam logic [2:0] OP_DOWN  = 3'd4;
  localparam logic [2:0] OP_HOLD  = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_EVAL,
    ST_DONE,
    ST_GAP
  } op_state_e;

endpackage

// File: rtl/player_op_exec.sv
// Applies one player op to the active piece, querying the collision checker per candidate.
// Owns piece position/rotation and the once-per-piece hold permission.
//  state | meaning
//  IDLE  | waiting for an op while op_state_en_i is high
//  CHECK | candidate presented on chk_*, waiting for chk_ack_i
//  EVAL  | apply registered checker verdict; hard drop may loop back to CHECK
//  DONE  | op_executed_o (plus hold_req_o / drop_done_o) for one cycle
//  GAP   | one idle cycle so the input stage can retire the op
module player_op_exec
  import player_op_exec_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   op_state_en_i,
  input  logic [2:0]             next_op_type_i,
  input  logic                   spawn_i,
  input  logic [X_W-1:0]         spawn_x_i,
  input  logic [Y_W-1:0]         spawn_y_i,
  output logic                   chk_req_o,
  output logic [X_W-1:0]         chk_x_o,
  output logic [Y_W-1:0]         chk_y_o,
  output logic [PIECE_ROT_W-1:0] chk_rot_o,
  input  logic                   chk_ack_i,
  input  logic                   chk_hit_i,
  output logic [X_W-1:0]         piece_x_o,
  output logic [Y_W-1:0]         piece_y_o,
  output logic [PIECE_ROT_W-1:0] piece_rot_o,
  output logic                   op_executed_o,
  output logic                   hold_valid_o,
  output logic                   hold_req_o,
  output logic                   drop_done_o
);

  op_state_e                state_q, state_d;
  logic [2:0]               op_q, op_d;
  logic [X_W-1:0]           x_q, x_d, cx_q, cx_d;
  logic [Y_W-1:0]           y_q, y_d, cy_q, cy_d;
  logic [PIECE_ROT_W-1:0]   rot_q, rot_d, cr_q, cr_d;
  logic                     hv_q, hv_d, hit_q, hit_d;
  logic                     drop_q, drop_d, hold_q, hold_d;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    x_d     = x_q;
    y_d     = y_q;
    rot_d   = rot_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    cr_d    = cr_q;
    hv_d    = hv_q;
    hit_d   = hit_q;
    drop_d  = drop_q;
    hold_d  = hold_q;

    unique case (state_q)
      ST_IDLE: begin
        drop_d = 1'b0;
        hold_d = 1'b0;
        cx_d   = x_q;
        cy_d   = y_q;
        cr_d   = rot_q;
        if (op_state_en_i) begin
          op_d = next_op_type_i;
          case (next_op_type_i)
            OP_LEFT: begin
              if (x_q == '0) state_d = ST_DONE;
              else begin
                cx_d    = x_q - 1'b1;
                state_d = ST_CHECK;
              end
            end
            OP_RIGHT: begin
              cx_d    = x_q + 1'b1;
              state_d = ST_CHECK;
            end
            OP_SPIN: begin
              cr_d    = rot_q + 1'b1;
              state_d = ST_CHECK;
            end
            OP_DOWN: begin
              if (y_q == Y_LAST) begin
                drop_d  = 1'b1;
                state_d = ST_DONE;
              end else begin
                cy_d    = y_q + 1'b1;
                state_d = ST_CHECK;
              end
            end
            OP_HOLD: begin
              hold_d  = hv_q;
              hv_d    = 1'b0;
              state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end
      ST_CHECK: begin
        if (chk_ack_i) begin
          hit_d   = chk_hit_i;
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        state_d = ST_DONE;
        if (!hit_q) begin
          x_d   = cx_q;
          y_d   = cy_q;
          rot_d = cr_q;
        end
        // Hard drop keeps stepping down until a hit or the bottom row
        if (op_q == OP_DOWN) begin
          if (hit_q || cy_q == Y_LAST) drop_d = 1'b1;
          else begin
            cy_d    = cy_q + 1'b1;
            state_d = ST_CHECK;
          end
        end
      end
      ST_DONE: state_d = ST_GAP;
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (spawn_i) begin
      state_d = ST_IDLE;
      x_d     = spawn_x_i;
      y_d     = spawn_y_i;
      rot_d   = '0;
      hv_d    = 1'b1;
      drop_d  = 1'b0;
      hold_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NULL;
      x_q     <= '0;
      y_q     <= '0;
      rot_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      cr_q    <= '0;
      hv_q    <= 1'b1;
      hit_q   <= 1'b0;
      drop_q  <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      x_q     <= x_d;
      y_q     <= y_d;
      rot_q   <= rot_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      cr_q    <= cr_d;
      hv_q    <= hv_d;
      hit_q   <= hit_d;
      drop_q  <= drop_d;
      hold_q  <= hold_d;
    end
  end

  // A same-cycle spawn or reset swallows the retirement pulses
  logic pulse_ok;
  assign pulse_ok      = (state_q == ST_DONE) && !spawn_i && !reset;
  assign op_executed_o = pulse_ok;
  assign hold_req_o    = pulse_ok && hold_q;
  assign drop_done_o   = pulse_ok && drop_q;

  assign chk_req_o   = (state_q == ST_CHECK);
  assign chk_x_o     = cx_q;
  assign chk_y_o     = cy_q;
  assign chk_rot_o   = cr_q;
  assign piece_x_o   = x_q;
  assign piece_y_o   = y_q;
  assign piece_rot_o = rot_q;
  assign hold_valid_o = hv_q;

endmodule

// File: tb/tb_player_op_exec.sv
// Random and directed ops against a behavioural piece model; the bench also plays the
// collision checker with a small board bitmap and variable response latency.
module tb_player_op_exec;
  import player_op_exec_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic op_state_en = 1'b0;
  logic [2:0] next_op_type = OP_NULL;
  logic spawn = 1'b0;
  logic [X_W-1:0] spawn_x = '0;
  logic [Y_W-1:0] spawn_y = '0;
  logic chk_req, chk_ack, chk_hit;
  logic [X_W-1:0] chk_x, piece_x;
  logic [Y_W-1:0] chk_y, piece_y;
  logic [PIECE_ROT_W-1:0] chk_rot, piece_rot;
  logic op_executed, hold_valid, hold_req, drop_done;

  player_op_exec dut (
    .clk(clk), .reset(reset), .op_state_en_i(op_state_en), .next_op_type_i(next_op_type),
    .spawn_i(spawn), .spawn_x_i(spawn_x), .spawn_y_i(spawn_y),
    .chk_req_o(chk_req), .chk_x_o(chk_x), .chk_y_o(chk_y), .chk_rot_o(chk_rot),
    .chk_ack_i(chk_ack), .chk_hit_i(chk_hit),
    .piece_x_o(piece_x), .piece_y_o(piece_y), .piece_rot_o(piece_rot),
    .op_executed_o(op_executed), .hold_valid_o(hold_valid), .hold_req_o(hold_req),
    .drop_done_o(drop_done));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Board environment
  bit blk[0:15][0:31];
  bit force_hit = 1'b0;
  int fixed_lat = 0;
  int nq = 0;
  int ack_cyc = 0;
  int unstable = 0;

  function automatic bit hit_at(input int x, input int y);
    if (force_hit) return 1'b1;
    if (x < 0 || x > 9 || y < 0 || y > BOARD_H - 1) return 1'b1;
    return blk[x][y];
  endfunction

  task automatic clear_board();
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 32; y++) blk[x][y] = 1'b0;
  endtask

  // Checker responder: 1..3 cycle latency, drops the query if chk_req goes away
  initial begin
    int lat;
    logic [X_W-1:0] lx;
    logic [Y_W-1:0] ly;
    logic [PIECE_ROT_W-1:0] lr;
    chk_ack = 1'b0;
    chk_hit = 1'b0;
    forever begin
      @(negedge clk);
      if (chk_req && !reset) begin
        lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 3));
        lx = chk_x; ly = chk_y; lr = chk_rot;
        for (int i = 1; i < lat; i++) begin
          @(negedge clk);
          if (chk_req && (chk_x != lx || chk_y != ly || chk_rot != lr)) unstable++;
        end
        if (chk_req && !reset) begin
          chk_ack = 1'b1;
          chk_hit = hit_at(int'(chk_x), int'(chk_y));
          nq++;
          ack_cyc = cyc;
          @(negedge clk);
          chk_ack = 1'b0;
          chk_hit = 1'b0;
        end
      end
    end
  end

  // Reference piece state
  int m_x = 0, m_y = 0, m_rot = 0;
  bit m_hv = 1'b1;

  task automatic check_piece(input string tag);
    check({tag, ".x"}, int'(piece_x), m_x);
    check({tag, ".y"}, int'(piece_y), m_y);
    check({tag, ".rot"}, int'(piece_rot), m_rot);
    check({tag, ".hv"}, int'(hold_valid), int'(m_hv));
  endtask

  task automatic do_spawn(input int x, input int y);
    @(negedge clk);
    spawn = 1'b1;
    spawn_x = X_W'(x);
    spawn_y = Y_W'(y);
    @(negedge clk);
    spawn = 1'b0;
    m_x = x; m_y = y; m_rot = 0; m_hv = 1'b1;
    check("spawn.exec", int'(op_executed), 0);
    check_piece("spawn");
  endtask

  task automatic do_op(input logic [2:0] op, input string tag);
    int q_exp = 0, nq0, issue, exec_cyc = -1, n_exec = 0, n_hold = 0, n_drop = 0;
    int drop_sync = 1, after = 0, waited = 0;
    bit h_exp = 0, d_exp = 0, retire = 1, imm = 0, req_seen = 0;
    int nr;
    case (op)
      OP_LEFT: if (m_x == 0) imm = 1;
               else begin q_exp = 1; if (!hit_at(m_x - 1, m_y)) m_x--; end
      OP_RIGHT: begin q_exp = 1; if (!hit_at(m_x + 1, m_y)) m_x++; end
      OP_SPIN: begin
        q_exp = 1;
        nr = (m_rot + 1) % 4;
        if (!hit_at(m_x, m_y)) m_rot = nr;
      end
      OP_DOWN: begin
        d_exp = 1;
        while (m_y < BOARD_H - 1) begin
          q_exp++;
          if (hit_at(m_x, m_y + 1)) break;
          m_y++;
        end
        imm = (q_exp == 0);
      end
      OP_HOLD: begin imm = 1; if (m_hv) begin h_exp = 1; m_hv = 0; end end
      default: retire = 0;
    endcase
    nq0 = nq;
    unstable = 0;
    @(negedge clk);
    op_state_en = 1'b1;
    next_op_type = op;
    issue = cyc;
    @(negedge clk);
    op_state_en = 1'b0;
    next_op_type = OP_NULL;
    while (waited < 400 && after < 4 && !(!retire && waited >= 5)) begin
      if (chk_req) req_seen = 1;
      if (op_executed) begin n_exec++; exec_cyc = cyc; end
      if (hold_req) n_hold++;
      if (drop_done) begin n_drop++; if (!op_executed) drop_sync = 0; end
      if (n_exec > 0) after++;
      @(negedge clk);
      waited++;
    end
    check({tag, ".timeout"}, int'(waited >= 400), 0);
    check({tag, ".exec"}, n_exec, int'(retire));
    check({tag, ".hold_req"}, n_hold, int'(h_exp));
    check({tag, ".drop"}, n_drop, int'(d_exp));
    check({tag, ".drop_sync"}, drop_sync, 1);
    check({tag, ".queries"}, nq - nq0, q_exp);
    check({tag, ".stable"}, unstable, 0);
    if (imm || !retire) check({tag, ".req_seen"}, int'(req_seen), 0);
    if (retire && n_exec == 1) begin
      if (imm) check({tag, ".lat"}, exec_cyc - issue, 1);
      else     check({tag, ".lat"}, exec_cyc - ack_cyc, 2);
    end
    check_piece(tag);
  endtask

  initial begin
    int n_exec;
    logic [2:0] ops[6];
    ops = '{OP_LEFT, OP_RIGHT, OP_SPIN, OP_DOWN, OP_HOLD, OP_NULL};
    clear_board();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst.req", int'(chk_req), 0);
    check("rst.exec", int'(op_executed), 0);
    check_piece("rst");

    // Left with a 3-cycle checker, then left at the wall
    fixed_lat = 3;
    do_spawn(5, 3);
    do_op(OP_LEFT, "left5");
    fixed_lat = 0;
    do_spawn(0, 3);
    do_op(OP_LEFT, "left0");

    // Spin wrap, then a rejected spin
    do_spawn(4, 4);
    for (int i = 0; i < 4; i++) do_op(OP_SPIN, "spin_wrap");
    for (int i = 0; i < 3; i++) do_op(OP_SPIN, "spin_to3");
    force_hit = 1'b1;
    do_op(OP_SPIN, "spin_hit");
    force_hit = 1'b0;

    // Hard drop onto a block at row 7, and to the floor
    blk[4][7] = 1'b1;
    do_spawn(4, 2);
    do_op(OP_DOWN, "drop7");
    check("drop7.y", int'(piece_y), 6);
    clear_board();
    do_spawn(2, 17);
    do_op(OP_DOWN, "drop_floor");
    do_op(OP_DOWN, "drop_bottom");
    do_op(OP_RIGHT, "right");
    do_spawn(9, 0);
    do_op(OP_RIGHT, "right_wall");

    // Hold once per piece
    do_op(OP_HOLD, "hold1");
    do_op(OP_HOLD, "hold2");
    do_spawn(1, 1);
    do_op(OP_NULL, "null");

    // Spawn while a query is outstanding
    fixed_lat = 8;
    @(negedge clk);
    op_state_en = 1'b1;
    next_op_type = OP_RIGHT;
    @(negedge clk);
    op_state_en = 1'b0;
    next_op_type = OP_NULL;
    @(negedge clk);
    check("abort.req_before", int'(chk_req), 1);
    spawn = 1'b1; spawn_x = 4'd3; spawn_y = 5'd0;
    n_exec = 0;
    @(negedge clk);
    spawn = 1'b0;
    m_x = 3; m_y = 0; m_rot = 0; m_hv = 1'b1;
    check("abort.req_after", int'(chk_req), 0);
    for (int i = 0; i < 10; i++) begin
      if (op_executed) n_exec++;
      @(negedge clk);
    end
    check("abort.exec", n_exec, 0);
    check_piece("abort");

    // Reset in the middle of a hard drop
    fixed_lat = 2;
    @(negedge clk);
    op_state_en = 1'b1;
    next_op_type = OP_DOWN;
    @(negedge clk);
    op_state_en = 1'b0;
    next_op_type = OP_NULL;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    n_exec = 0;
    for (int i = 0; i < 3; i++) begin
      if (op_executed || drop_done) n_exec++;
      @(negedge clk);
    end
    reset = 1'b0;
    m_x = 0; m_y = 0; m_rot = 0; m_hv = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (op_executed || drop_done || chk_req) n_exec++;
      @(negedge clk);
    end
    check("rstmid.pulses", n_exec, 0);
    check_piece("rstmid");
    fixed_lat = 0;

    // Random ops on a sparse random board
    for (int x = 0; x < 10; x++)
      for (int y = 0; y < BOARD_H; y++) blk[x][y] = ($urandom_range(0, 9) == 0);
    do_spawn(int'($urandom_range(0, 9)), int'($urandom_range(0, 10)));
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 11) == 0)
        do_spawn(int'($urandom_range(0, 9)), int'($urandom_range(0, 19)));
      else
        do_op(ops[$urandom_range(0, 5)], "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=%0d", cyc, 0);
    $fatal(1, "global timeout");
  end

endmodule
